// File: rtl/rv_core_pkg.sv
// Shared core definitions: opcodes, fetch FSM states, instruction size.
package rv_core_pkg;

    localparam int unsigned INST_BYTES = 4;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_NOP    = 7'b0000000;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

endpackage : rv_core_pkg

// File: rtl/pc_fetch_unit_if.sv
// Fetch-stage bus: decoded flags in, PC/status out.
interface pc_fetch_unit_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
);
    logic             stall;
    logic             branch;
    logic             jump;
    logic             take_branch;
    logic [6:0]       opcode;
    logic [WIDTH-1:0] imm;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] offset;
    logic [WIDTH-1:0] pc_plus4;
    logic             valid;
    logic             halted;
    logic             misaligned;
    logic [CNT_W-1:0] retired_count;

    modport master (
        output stall, branch, jump, take_branch, opcode, imm,
        input  pc, offset, pc_plus4, valid, halted, misaligned, retired_count
    );

    modport slave (
        input  stall, branch, jump, take_branch, opcode, imm,
        output pc, offset, pc_plus4, valid, halted, misaligned, retired_count
    );
endinterface : pc_fetch_unit_if

// File: rtl/pc_fetch_unit.sv
// Program counter stage: next-PC selection, halt detection, retire counter.
module pc_fetch_unit
    import rv_core_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned NUM_INST = 19,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    pc_fetch_unit_if.slave    bus
);

    localparam logic [WIDTH-1:0] STEP  = WIDTH'(INST_BYTES);
    localparam logic [WIDTH-1:0] LIMIT = WIDTH'(NUM_INST * INST_BYTES);

    fetch_state_t     state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             valid_q, valid_d;
    logic             halted_q, halted_d;
    logic             mis_q, mis_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] seq_pc;
    logic [WIDTH-1:0] tgt_pc;
    logic [WIDTH-1:0] next_pc;
    logic             redirect;

    // Link value and redirect target are combinational from the live PC.
    assign seq_pc = pc_q + STEP;
    assign tgt_pc = pc_q + bus.imm;

    assign bus.pc            = pc_q;
    assign bus.offset        = tgt_pc;
    assign bus.pc_plus4      = seq_pc;
    assign bus.valid         = valid_q;
    assign bus.halted        = halted_q;
    assign bus.misaligned    = mis_q;
    assign bus.retired_count = cnt_q;

    // State and PC registers; reset discards any in-flight redirect.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= BOOT;
            pc_q     <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            mis_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
            mis_q    <= mis_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state: program end beats stall, jump beats branch, then checks.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        valid_d  = valid_q;
        halted_d = halted_q;
        mis_d    = mis_q;
        cnt_d    = cnt_q;
        redirect = bus.jump | (bus.branch & bus.take_branch);
        next_pc  = redirect ? tgt_pc : seq_pc;

        case (state_q)
            BOOT: begin
                state_d = RUN;
                valid_d = 1'b1;
            end
            RUN: begin
                if (bus.opcode == OP_NOP) begin
                    state_d  = HALT;
                    valid_d  = 1'b0;
                    halted_d = 1'b1;
                end else if (bus.stall) begin
                    pc_d = pc_q;
                end else if (redirect && (next_pc[1:0] != 2'b00)) begin
                    state_d  = HALT;
                    valid_d  = 1'b0;
                    halted_d = 1'b1;
                    mis_d    = 1'b1;
                end else if (next_pc >= LIMIT) begin
                    state_d  = HALT;
                    valid_d  = 1'b0;
                    halted_d = 1'b1;
                end else begin
                    pc_d  = next_pc;
                    cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
                end
            end
            HALT: begin
                valid_d  = 1'b0;
                halted_d = 1'b1;
            end
            default: begin
                state_d = BOOT;
                valid_d = 1'b0;
            end
        endcase
    end

endmodule : pc_fetch_unit
